// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types for the multi-read-port register file
// Contents:
//   clr_state_t - clear engine state encoding (ST_IDLE, ST_CLEARING)
package regfile_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// rtl/regfile_clear_ctrl.sv - sequential zero-fill engine for the register file
// Walks every entry once, one entry per clock, after reset or on clear_req.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear_req   - single-cycle request to start a clear (ignored while clearing)
//   clear_busy  - high while the engine owns the array write port
//   clr_we      - clear write enable toward the array
//   clr_addr    - entry being zeroed this cycle
module regfile_clear_ctrl #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    import regfile_pkg::*;

    clr_state_t        state;
    logic [ADDR_W-1:0] idx;

    // Reset lands directly in CLEARING so the array never exposes
    // uninitialised contents after power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEARING;
            idx        <= '0;
            clear_busy <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state      <= ST_CLEARING;
                        idx        <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                ST_CLEARING: begin
                    // idx wraps to 0 on the last entry, ready for the next run.
                    idx <= idx + 1'b1;
                    if (idx == ADDR_W'(DEPTH - 1)) begin
                        state      <= ST_IDLE;
                        clear_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEARING);
    assign clr_addr = idx;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised register file, one write port, NUM_READ registered read ports
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   raddr       - NUM_READ packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata       - NUM_READ packed registered read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   we, waddr, wdata - write port
//   clear_req   - pulse to zero every entry
//   clear_busy  - high while the clear engine runs; reads return 0, writes are dropped
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 0,
    parameter int ZERO_REG   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*ADDR_W-1:0]     raddr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
    input  logic                           we,
    input  logic [ADDR_W-1:0]              waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           clear_req,
    output logic                           clear_busy
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  clr_we;
    logic [ADDR_W-1:0]     clr_addr;
    logic                  user_we;

    regfile_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr)
    );

    // A write that will actually land in the array; this same qualifier
    // gates bypass so a dropped write can never be forwarded.
    assign user_we = we && !clear_busy && !((ZERO_REG != 0) && (waddr == '0));

    // Storage is deliberately not reset; the clear engine initialises it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0]     ra;
        logic [DATA_WIDTH-1:0] rd_q;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (clear_busy) begin
                rd_q <= '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_q <= '0;
            end else if ((BYPASS != 0) && user_we && (waddr == ra)) begin
                rd_q <= wdata;
            end else begin
                rd_q <= mem[ra];
            end
        end

        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized self-checking bench for regfile_mp (two configurations side by side)
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              we = 1'b0;
    logic              clear_req = 1'b0;
    logic [AW-1:0]     waddr = '0;
    logic [DW-1:0]     wdata = '0;
    logic [NR*AW-1:0]  raddr = '0;
    logic [NR*DW-1:0]  rdata0, rdata1;
    logic              busy0, busy1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // dut0: BYPASS=0, ZERO_REG=0 ; dut1: BYPASS=1, ZERO_REG=1
    regfile_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ(NR), .BYPASS(0), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata0), .we(we),
        .waddr(waddr), .wdata(wdata), .clear_req(clear_req), .clear_busy(busy0));

    regfile_mp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ(NR), .BYPASS(1), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata1), .we(we),
        .waddr(waddr), .wdata(wdata), .clear_req(clear_req), .clear_busy(busy1));

    // Behavioural model: d selects configuration (d==1 means bypass + zero reg).
    logic [DW-1:0] mm     [2][DEPTH];
    logic [DW-1:0] exp_rd [2][NR];
    bit            busy_m;
    int            left;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [DW-1:0] get_rd(input int d, input int k);
        return (d == 0) ? rdata0[k*DW +: DW] : rdata1[k*DW +: DW];
    endfunction

    task automatic model_reset();
        busy_m = 1'b1;
        left   = DEPTH;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NR; k++) exp_rd[d][k] = '0;
            for (int i = 0; i < DEPTH; i++) mm[d][i] = '0;
        end
    endtask

    task automatic model_step();
        bit wr_ok;
        int a;
        for (int d = 0; d < 2; d++) begin
            wr_ok = we && !busy_m && !(d == 1 && waddr == 0);
            for (int k = 0; k < NR; k++) begin
                a = int'(raddr[k*AW +: AW]);
                if (busy_m)                                exp_rd[d][k] = '0;
                else if (d == 1 && a == 0)                 exp_rd[d][k] = '0;
                else if (d == 1 && wr_ok && int'(waddr) == a) exp_rd[d][k] = wdata;
                else                                       exp_rd[d][k] = mm[d][a];
            end
            if (wr_ok) mm[d][waddr] = wdata;
        end
        if (busy_m) begin
            left--;
            if (left == 0) busy_m = 1'b0;
        end else if (clear_req) begin
            // Contents are unobservable while busy, so zeroing everything at
            // the start is equivalent to the entry-by-entry sweep.
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < DEPTH; i++) mm[d][i] = '0;
            busy_m = 1'b1;
            left   = DEPTH;
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NR; k++)
                check($sformatf("model_rd d%0d p%0d", d, k), get_rd(d, k), exp_rd[d][k]);
        check("model_busy0", {31'b0, busy0}, {31'b0, busy_m});
        check("model_busy1", {31'b0, busy1}, {31'b0, busy_m});
    end

    task automatic rnd_inputs(input bit force_we);
        we        = force_we ? 1'b1 : 1'($urandom_range(0, 1));
        waddr     = AW'($urandom);
        wdata     = $urandom;
        raddr     = (NR*AW)'($urandom);
        clear_req = 1'b0;
    endtask

    task automatic measure_busy(input bit force_we, input bit second_pulse, output int n);
        n = busy0 ? 1 : 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (!busy0) break;
            n++;
            @(negedge clk);
            rnd_inputs(force_we);
            if (second_pulse && n == 10) clear_req = 1'b1;
        end
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < DEPTH; i += NR) begin
            @(negedge clk);
            we = 1'b0; clear_req = 1'b0;
            for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = AW'(i + k);
            @(posedge clk); #1;
            for (int k = 0; k < NR; k++) begin
                check(name, get_rd(0, k), '0);
                check(name, get_rd(1, k), '0);
            end
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        we = 1'b0; clear_req = 1'b0;
        for (int c = 0; c < 80 && busy0; c++) @(negedge clk);
        check("wait_idle", {31'b0, busy0}, 32'd0);
    endtask

    task automatic write_at_negedge(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        we = 1'b1; waddr = AW'(a); wdata = v; clear_req = 1'b0;
    endtask

    initial begin
        int n;
        rnd_inputs(1'b1);
        repeat (3) @(negedge clk);

        // Post-reset clear with writes held on
        @(negedge clk);
        rst_n = 1'b1;
        measure_busy(1'b1, 1'b0, n);
        check("post_reset_busy_cycles", n, 32);
        read_all_zero("post_reset_zero");

        // Basic write/read
        write_at_negedge(5, 32'hDEADBEEF);
        raddr = '0;
        @(negedge clk);
        we = 1'b0;
        raddr[0*AW +: AW] = 5'd5;
        raddr[1*AW +: AW] = 5'd5;
        @(posedge clk); #1;
        check("basic_p0", get_rd(0, 0), 32'hDEADBEEF);
        check("basic_p1", get_rd(0, 1), 32'hDEADBEEF);
        check("basic_bypass_p0", get_rd(1, 0), 32'hDEADBEEF);

        // Collision
        write_at_negedge(7, 32'h11);
        write_at_negedge(7, 32'h22);
        raddr[0*AW +: AW] = 5'd7;
        @(posedge clk); #1;
        check("collide_old", get_rd(0, 0), 32'h11);
        check("collide_bypass", get_rd(1, 0), 32'h22);
        @(negedge clk);
        we = 1'b0;
        @(posedge clk); #1;
        check("collide_next", get_rd(0, 0), 32'h22);

        // Zero register
        write_at_negedge(0, 32'hFFFFFFFF);
        raddr[0*AW +: AW] = 5'd0;
        @(posedge clk); #1;
        check("zero_reg_same", get_rd(1, 0), 32'h0);
        check("r0_plain_old", get_rd(0, 0), 32'h0);
        @(negedge clk);
        we = 1'b0;
        @(posedge clk); #1;
        check("zero_reg_after", get_rd(1, 0), 32'h0);
        check("r0_plain_new", get_rd(0, 0), 32'hFFFFFFFF);

        // Random traffic with occasional clears
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            rnd_inputs(1'b0);
            clear_req = ($urandom_range(0, 63) == 0);
        end
        wait_idle();

        // Runtime clear with a second request mid-clear
        for (int i = 0; i < DEPTH; i++) write_at_negedge(i, DW'(i + 1));
        @(negedge clk);
        we = 1'b0;
        for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = AW'(31 - k);
        @(posedge clk); #1;
        check("fill_r31", get_rd(0, 0), 32'd32);
        @(negedge clk);
        clear_req = 1'b1;
        measure_busy(1'b0, 1'b1, n);
        check("runtime_busy_cycles", n, 32);
        read_all_zero("runtime_clear_zero");

        // Reset in the middle of a clear
        @(negedge clk);
        clear_req = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            rnd_inputs(1'b0);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NR; k++) begin
            check("midclear_rst_rd0", get_rd(0, k), '0);
            check("midclear_rst_rd1", get_rd(1, k), '0);
        end
        check("midclear_rst_busy", {31'b0, busy0}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        measure_busy(1'b0, 1'b0, n);
        check("rst_restart_busy_cycles", n, 32);

        // Four ports, four distinct entries
        write_at_negedge(3, 32'hA0A0_0003);
        write_at_negedge(9, 32'hB0B0_0009);
        write_at_negedge(17, 32'hC0C0_0011);
        write_at_negedge(30, 32'hD0D0_001E);
        @(negedge clk);
        we = 1'b0;
        raddr = {5'd30, 5'd17, 5'd9, 5'd3};
        @(posedge clk); #1;
        check("mp_p0", get_rd(0, 0), 32'hA0A0_0003);
        check("mp_p1", get_rd(0, 1), 32'hB0B0_0009);
        check("mp_p2", get_rd(0, 2), 32'hC0C0_0011);
        check("mp_p3", get_rd(1, 3), 32'hD0D0_001E);

        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            rnd_inputs(1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the single-write / two-read 32x32 register file in the datapath.
- Widths, depth and read-port count are configurable.
- Supports a selectable same-cycle read/write collision policy and an optional hardwired zero register.
- Zero-initialisation is done by a sequential clear engine, run after reset or on request, instead of simulation-only initialisation.

Parameters:
- DATA_WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; must be a power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address width (derived; do not override).
- NUM_READ, 2, number of read ports (1..8).
- BYPASS, 0: read of an address being written returns the old value. 1: it returns the new write data (write-through).
- ZERO_REG, 0: entry 0 is ordinary storage. 1: entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  NUM_READ*ADDR_W  read addresses; port k occupies [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_READ*DATA_WIDTH  registered read data; port k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_WIDTH  write data.
- clear_req  in  1  single-cycle pulse requesting zeroing of all entries.
- clear_busy  out  1  high while the clear engine runs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all rdata := 0; clear_busy := 1; FSM := CLEARING; clear index := 0.
  - Storage array is not reset directly.
- FSM states:
  - IDLE: normal operation; clear_busy = 0. clear_req = 1 -> CLEARING with index 0 on the next edge.
  - CLEARING: each edge writes 0 to entry[index], then index += 1.
  - When index == DEPTH-1 is written, go to IDLE; clear_busy falls on that same edge.
  - Total clear time is DEPTH cycles; index wraps naturally at ADDR_W bits.
  - clear_req while CLEARING is ignored; the sequence does not restart.
- Read:
  - 1-cycle latency: rdata[k] at edge N+1 reflects raddr[k] sampled at edge N.
  - All ports are independent; any number of ports may read the same address.
  - While clear_busy = 1, every rdata[k] := 0 regardless of array contents.
- Write: when we = 1, FSM = IDLE and the address is writable, entry[waddr] := wdata at the edge.
  - Writes while clear_busy = 1 are dropped silently.
  - Writes to entry 0 are dropped when ZERO_REG = 1.
- Collision (we = 1, FSM = IDLE, waddr == raddr[k] on the same edge):
  - BYPASS = 0: rdata[k] := previous contents; the new value is visible on the next read.
  - BYPASS = 1: rdata[k] := wdata.
  - A dropped write (ZERO_REG entry 0) never bypasses; rdata[k] := 0.
- ZERO_REG = 1: a read of address 0 returns 0 always. This holds in either BYPASS mode.
- clear_req and we in the same IDLE cycle: the write is committed first. The clear then zeroes that entry, so the write is lost.
- Reset asserted mid-clear: the clear restarts from index 0 after rst_n deasserts.
- No X propagation: rdata must never be X after the first post-reset clear completes.

Decomposition:
- Shared package (regfile_pkg): clog2 helper if the toolchain needs it, and the FSM state encoding (ST_IDLE, ST_CLEARING).
- One sub-module, regfile_clear_ctrl: owns the FSM, the index counter, clear_busy, and the clear-write address/enable.
- Top level: array, write mux (clear vs user), per-port read/bypass logic.

Test Plan:
- Post-reset clear: release rst_n, hold we = 1 throughout. Expect clear_busy high for exactly 32 cycles, rdata = 0 during that time, and all 32 entries read 0 afterwards (writes dropped).
- Basic write/read: write 0xDEADBEEF to r5, then read r5 on both ports. Expect 0xDEADBEEF one cycle after the address is applied.
- Collision:
  - Setup: r7 = 0x11; same cycle write r7 = 0x22 with raddr0 = 7.
  - BYPASS = 0: rdata0 = 0x11, then 0x22 next cycle.
  - BYPASS = 1: rdata0 = 0x22 immediately.
- ZERO_REG = 1: write 0xFFFFFFFF to r0 with raddr0 = 0 the same cycle. Expect rdata0 = 0 in that cycle and all later cycles.
- Runtime clear:
  - Setup: fill r0..r31 with index+1, then pulse clear_req.
  - Pulse clear_req again mid-clear: expect no restart, clear_busy for exactly 32 cycles.
  - Expect all entries 0 after the clear completes.
- Reset mid-clear and multi-port: assert rst_n low at clear index 10. Expect rdata = 0 immediately and a full 32-cycle clear after release. Then with NUM_READ = 4, read four distinct entries and confirm each port's data is correct.
